// File: rtl/mdio_bus_arbiter.sv
// Round-robin arbiter for the shared MDIO bus: one-cycle grant latency from IDLE, no preemption,
// enforced idle gap between owners, and a watchdog that revokes and locks out a hung owner.
module mdio_bus_arbiter #(
  parameter int N_REQ   = 2,
  parameter int GAP     = 4,
  parameter int TIMEOUT = 65536
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [1:0]       owner,
  output logic             busy,
  output logic             timeout_evt,
  output logic [1:0]       timeout_id
);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  localparam int               TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0]    TLIM = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [7:0]       GAP8 = 8'(GAP);
  localparam logic [N_REQ-1:0] ONE  = N_REQ'(1);

  state_t           state;
  logic [1:0]       last;
  logic [N_REQ-1:0] lock;
  logic [TW-1:0]    tcnt;
  logic [7:0]       gapcnt;

  logic [3:0] req4;
  logic [3:0] elig4;
  logic       win_vld;
  logic [1:0] win_idx;
  logic [1:0] idx;

  assign req4  = 4'(req);
  assign elig4 = 4'(req & ~lock);

  // Scan starts just after the last winner, so the previous owner has lowest priority.
  always_comb begin
    win_vld = 1'b0;
    win_idx = 2'd0;
    idx     = 2'd0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = 2'((int'(last) + k) % N_REQ);
      if (!win_vld && elig4[idx]) begin
        win_vld = 1'b1;
        win_idx = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      last        <= 2'(N_REQ - 1);
      lock        <= '0;
      tcnt        <= '0;
      gapcnt      <= '0;
      gnt         <= '0;
      owner       <= '0;
      busy        <= 1'b0;
      timeout_evt <= 1'b0;
      timeout_id  <= '0;
    end else begin
      timeout_evt <= 1'b0;
      lock        <= lock & req;
      case (state)
        IDLE: begin
          if (win_vld) begin
            gnt   <= ONE << win_idx;
            owner <= win_idx;
            last  <= win_idx;
            tcnt  <= '0;
            busy  <= 1'b1;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (tcnt != '1) tcnt <= tcnt + 1'b1;
          // A req drop that coincides with expiry wins: plain release, no lock.
          if (!req4[owner] || (TIMEOUT != 0 && tcnt == TLIM)) begin
            gnt   <= '0;
            owner <= '0;
            if (req4[owner]) begin
              timeout_evt <= 1'b1;
              timeout_id  <= owner;
              lock        <= (lock & req) | (ONE << owner);
            end
            if (GAP == 0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state  <= RELEASE;
              gapcnt <= GAP8;
            end
          end
        end
        RELEASE: begin
          if (gapcnt == 8'd1) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gapcnt <= gapcnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
